// File: rtl/udp_dump_framer.sv
// udp_dump_framer
//   Frames an order-book dump as a UDP byte stream: 42-byte Ethernet/IPv4/UDP
//   header, 3-byte dump-response opcode, then each 32-bit book entry sent
//   big-endian. A dump_empty pulse produces an empty-book frame: header,
//   opcode, then one 0x00 pad byte.
//
//   Optional build macro DUMP_LIMIT_EN: caps a frame at MAX_ENTRIES entries.
//   The capping entry's last byte carries tlast, dump_overflow is set (sticky),
//   and the rest of the dump is discarded up to its tlast entry.
//
// Ports
//   clk_udp, rst_udp_n         clock, asynchronous active-low reset
//   entry_tdata/tvalid/tlast   order-book entry input stream
//   entry_tready               entry accepted when tvalid && tready
//   dump_empty                 one-cycle pulse requesting an empty-book frame
//   tx_axis_*                  registered byte-stream egress
//   busy                       high whenever a frame is in progress
//   dump_overflow              sticky entry-limit flag (0 without DUMP_LIMIT_EN)
module udp_dump_framer #(
  parameter logic [31:0] SRC_IP      = 32'hC0A80132,
  parameter logic [31:0] DST_IP      = 32'hC0A80164,
  parameter logic [15:0] SRC_PORT    = 16'd55555,
  parameter logic [15:0] DST_PORT    = 16'd55555,
  parameter logic [23:0] OPCODE      = 24'hF0E0D0,
  parameter logic [15:0] MAX_ENTRIES = 16'd256
) (
  input  logic        clk_udp,
  input  logic        rst_udp_n,
  input  logic [31:0] entry_tdata,
  input  logic        entry_tvalid,
  input  logic        entry_tlast,
  output logic        entry_tready,
  input  logic        dump_empty,
  output logic [7:0]  tx_axis_tdata,
  output logic        tx_axis_tvalid,
  output logic        tx_axis_tlast,
  input  logic        tx_axis_tready,
  output logic        busy,
  output logic        dump_overflow
);

`ifdef DUMP_LIMIT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_OPCODE, S_LOAD, S_SEND, S_PAD, S_DRAIN
  } state_t;
  localparam bit LimitEn = 1'b1;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_OPCODE, S_LOAD, S_SEND, S_PAD
  } state_t;
  localparam bit LimitEn = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [5:0]  hdr_q, hdr_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] ent_q, ent_d;
  logic [31:0] word_q, word_d;
  logic        last_q, last_d;
  logic        dump_q, dump_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        accept;
  logic        at_limit;
  logic [1:0]  lane_inc;

  function automatic logic [7:0] hdr_byte(input logic [5:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      6'd12:   b = 8'h08;
      6'd23:   b = 8'h11;
      6'd26:   b = SRC_IP[31:24];
      6'd27:   b = SRC_IP[23:16];
      6'd28:   b = SRC_IP[15:8];
      6'd29:   b = SRC_IP[7:0];
      6'd30:   b = DST_IP[31:24];
      6'd31:   b = DST_IP[23:16];
      6'd32:   b = DST_IP[15:8];
      6'd33:   b = DST_IP[7:0];
      6'd34:   b = SRC_PORT[15:8];
      6'd35:   b = SRC_PORT[7:0];
      6'd36:   b = DST_PORT[15:8];
      6'd37:   b = DST_PORT[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] op_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = OPCODE[23:16];
      2'd1:    b = OPCODE[15:8];
      default: b = OPCODE[7:0];
    endcase
    return b;
  endfunction

  // The output registers always hold the byte of the current state/counter;
  // the state only advances when that byte is accepted, so tvalid is never
  // high in IDLE or LOAD and a stalled byte stays put.
  assign accept   = tvalid_q && tx_axis_tready;
  assign lane_inc = lane_q + 2'd1;
  // Entry about to be captured would be the MAX_ENTRIES-th without ending the dump.
  assign at_limit = LimitEn && ((ent_q + 16'd1) == MAX_ENTRIES) && !entry_tlast;

`ifdef DUMP_LIMIT_EN
  logic forced_q, forced_d;
  logic ovf_q, ovf_d;
  assign dump_overflow = ovf_q;
`else
  assign dump_overflow = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    lane_d       = lane_q;
    ent_d        = ent_q;
    word_d       = word_q;
    last_d       = last_q;
    dump_d       = dump_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    entry_tready = 1'b0;
`ifdef DUMP_LIMIT_EN
    forced_d     = forced_q;
    ovf_d        = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (entry_tvalid || dump_empty) begin
          state_d  = S_HEADER;
          dump_d   = entry_tvalid;
          hdr_d    = '0;
          lane_d   = '0;
          ent_d    = '0;
          tdata_d  = hdr_byte(6'd0);
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
        end
      end
      S_HEADER: begin
        if (accept) begin
          if (hdr_q == 6'd41) begin
            state_d = S_OPCODE;
            lane_d  = '0;
            tdata_d = op_byte(2'd0);
          end else begin
            hdr_d   = hdr_q + 6'd1;
            tdata_d = hdr_byte(hdr_q + 6'd1);
          end
        end
      end
      S_OPCODE: begin
        if (accept) begin
          if (lane_q == 2'd2) begin
            lane_d = '0;
            if (dump_q) begin
              state_d  = S_LOAD;
              tvalid_d = 1'b0;
            end else begin
              state_d = S_PAD;
              tdata_d = 8'h00;
              tlast_d = 1'b1;
            end
          end else begin
            lane_d  = lane_inc;
            tdata_d = op_byte(lane_inc);
          end
        end
      end
      S_LOAD: begin
        entry_tready = 1'b1;
        if (entry_tvalid) begin
          word_d   = entry_tdata;
          last_d   = entry_tlast | at_limit;
          ent_d    = ent_q + 16'd1;
`ifdef DUMP_LIMIT_EN
          forced_d = at_limit;
`endif
          state_d  = S_SEND;
          lane_d   = '0;
          tdata_d  = entry_tdata[31:24];
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
        end
      end
      S_SEND: begin
        if (accept) begin
          if (lane_q == 2'd3) begin
            lane_d   = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = last_q ? S_IDLE : S_LOAD;
`ifdef DUMP_LIMIT_EN
            if (forced_q) begin
              state_d = S_DRAIN;
              ovf_d   = 1'b1;
            end
`endif
          end else begin
            lane_d  = lane_inc;
            tdata_d = word_q[{~lane_inc, 3'b000} +: 8];
            tlast_d = last_q && (lane_inc == 2'd3);
          end
        end
      end
      S_PAD: begin
        if (accept) begin
          state_d  = S_IDLE;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
        end
      end
`ifdef DUMP_LIMIT_EN
      S_DRAIN: begin
        entry_tready = 1'b1;
        if (entry_tvalid && entry_tlast) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_udp or negedge rst_udp_n) begin
    if (!rst_udp_n) begin
      state_q  <= S_IDLE;
      hdr_q    <= '0;
      lane_q   <= '0;
      ent_q    <= '0;
      word_q   <= '0;
      last_q   <= 1'b0;
      dump_q   <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
`ifdef DUMP_LIMIT_EN
      forced_q <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      lane_q   <= lane_d;
      ent_q    <= ent_d;
      word_q   <= word_d;
      last_q   <= last_d;
      dump_q   <= dump_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
`ifdef DUMP_LIMIT_EN
      forced_q <= forced_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign tx_axis_tdata  = tdata_q;
  assign tx_axis_tvalid = tvalid_q;
  assign tx_axis_tlast  = tlast_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_udp_dump_framer.sv
// tb_udp_dump_framer
//   Directed bench for udp_dump_framer with default addresses/ports/opcode and
//   MAX_ENTRIES=4. Accepted egress bytes are collected as {tlast, tdata} and
//   compared against frames built from hand-written header bytes and the
//   entry words driven.
module tb_udp_dump_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] entry_tdata;
  logic        entry_tvalid;
  logic        entry_tlast;
  logic        entry_tready;
  logic        dump_empty;
  logic [7:0]  tx_tdata;
  logic        tx_tvalid;
  logic        tx_tlast;
  logic        tx_tready;
  logic        busy;
  logic        dump_overflow;

  int n_total = 0;
  int n_bad   = 0;
  int n_acc   = 0;

  logic [8:0]  rxq[$];
  logic [8:0]  expq[$];
  logic [31:0] ent_data[8];
  logic        ent_last[8];

  udp_dump_framer #(
    .MAX_ENTRIES(16'd4)
  ) dut (
    .clk_udp        (clk),
    .rst_udp_n      (rst_n),
    .entry_tdata    (entry_tdata),
    .entry_tvalid   (entry_tvalid),
    .entry_tlast    (entry_tlast),
    .entry_tready   (entry_tready),
    .dump_empty     (dump_empty),
    .tx_axis_tdata  (tx_tdata),
    .tx_axis_tvalid (tx_tvalid),
    .tx_axis_tlast  (tx_tlast),
    .tx_axis_tready (tx_tready),
    .busy           (busy),
    .dump_overflow  (dump_overflow)
  );

  always #5 clk = ~clk;

  // Inputs only change #1 after a rising edge, so a byte valid and ready
  // at the falling edge is the one accepted at the next rising edge.
  always @(negedge clk) begin
    if (tx_tvalid && tx_tready) rxq.push_back({tx_tlast, tx_tdata});
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hdr_exp(input int i);
    case (i)
      12: return 8'h08;
      23: return 8'h11;
      26: return 8'hC0;
      27: return 8'hA8;
      28: return 8'h01;
      29: return 8'h32;
      30: return 8'hC0;
      31: return 8'hA8;
      32: return 8'h01;
      33: return 8'h64;
      34: return 8'hD9;
      35: return 8'h03;
      36: return 8'hD9;
      37: return 8'h03;
      default: return 8'h00;
    endcase
  endfunction

  task automatic build_exp(input int n_ent, input bit empty);
    logic [31:0] w;
    expq.delete();
    for (int i = 0; i < 42; i++) expq.push_back({1'b0, hdr_exp(i)});
    expq.push_back(9'h0F0);
    expq.push_back(9'h0E0);
    expq.push_back(9'h0D0);
    if (empty) expq.push_back(9'h100);
    else begin
      for (int k = 0; k < n_ent; k++) begin
        w = ent_data[k];
        for (int l = 0; l < 4; l++)
          expq.push_back({1'((k == n_ent - 1) && (l == 3)), w[31 - 8*l -: 8]});
      end
    end
  endtask

  task automatic compare_frame(input string tag);
    check_eq({tag, " len"}, 32'(rxq.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < rxq.size(); i++)
      check_eq($sformatf("%s b%0d", tag, i), 32'(rxq[i]), 32'(expq[i]));
  endtask

  task automatic send_entries(input int n, input bit with_empty);
    bit acc;
    int cyc;
    for (int i = 0; i < n; i++) begin
      entry_tdata  = ent_data[i];
      entry_tlast  = ent_last[i];
      entry_tvalid = 1'b1;
      if (i == 0 && with_empty) dump_empty = 1'b1;
      acc = 1'b0;
      cyc = 0;
      while (!acc && cyc < 400) begin
        @(negedge clk);
        acc = entry_tready;
        @(posedge clk);
        #1;
        dump_empty = 1'b0;
        cyc++;
      end
      check_eq($sformatf("entry%0d accepted", i), 32'(acc), 32'd1);
      if (acc) n_acc++;
    end
    entry_tvalid = 1'b0;
    entry_tlast  = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk);
      #1;
      if (rxq.size() > 0 && rxq[$][8]) done = 1'b1;
    end
    check_eq({tag, " done"}, 32'(done), 32'd1);
  endtask

  task automatic pulse_empty();
    dump_empty = 1'b1;
    @(posedge clk);
    #1;
    dump_empty = 1'b0;
  endtask

  initial begin
    bit   any_last;
    bit   done;
    int   sz;
    int   n_frame;
    logic exp_ovf;

    rst_n        = 1'b0;
    entry_tdata  = '0;
    entry_tvalid = 1'b0;
    entry_tlast  = 1'b0;
    dump_empty   = 1'b0;
    tx_tready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst tdata", 32'(tx_tdata), 32'h0);
    check_eq("rst tvalid", 32'(tx_tvalid), 32'h0);
    check_eq("rst tlast", 32'(tx_tlast), 32'h0);
    check_eq("rst entry_tready", 32'(entry_tready), 32'h0);
    check_eq("rst busy", 32'(busy), 32'h0);
    check_eq("rst overflow", 32'(dump_overflow), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Two-entry dump frame, 53 bytes.
    ent_data[0] = 32'h00608013; ent_last[0] = 1'b0;
    ent_data[1] = 32'h0061802F; ent_last[1] = 1'b1;
    rxq.delete();
    fork
      send_entries(2, 1'b0);
      wait_frame("dump2");
    join
    repeat (3) @(posedge clk);
    #1;
    build_exp(2, 1'b0);
    compare_frame("dump2");
    check_eq("dump2 b45-48", {rxq[45][7:0], rxq[46][7:0], rxq[47][7:0], rxq[48][7:0]}, 32'h00608013);
    check_eq("dump2 b52", 32'(rxq[52]), 32'h12F);
    check_eq("dump2 busy after", 32'(busy), 32'h0);

    // Empty-book frame, 46 bytes.
    rxq.delete();
    pulse_empty();
    wait_frame("empty");
    repeat (3) @(posedge clk);
    #1;
    build_exp(0, 1'b1);
    compare_frame("empty");

    // Egress stalled for 5 cycles while payload byte 46 (0x60) is presented.
    rxq.delete();
    fork
      send_entries(2, 1'b0);
      wait_frame("stall");
      begin
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
          @(posedge clk);
          #1;
          if (rxq.size() == 46) done = 1'b1;
        end
        check_eq("stall reached b46", 32'(done), 32'd1);
        tx_tready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check_eq("stall tdata", 32'(tx_tdata), 32'h60);
          check_eq("stall tvalid", 32'(tx_tvalid), 32'h1);
        end
        @(posedge clk);
        #1;
        tx_tready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    build_exp(2, 1'b0);
    compare_frame("stall");

    // entry_tvalid and dump_empty together: one dump frame, no empty frame.
    ent_data[0] = 32'h12345678; ent_last[0] = 1'b1;
    rxq.delete();
    fork
      send_entries(1, 1'b1);
      wait_frame("both");
    join
    repeat (20) @(posedge clk);
    #1;
    build_exp(1, 1'b0);
    compare_frame("both");
    check_eq("both busy after", 32'(busy), 32'h0);

    // Six entries against MAX_ENTRIES=4.
    for (int i = 0; i < 6; i++) begin
      ent_data[i] = 32'hA0010001 + 32'h01010101 * 32'(i);
      ent_last[i] = (i == 5);
    end
`ifdef DUMP_LIMIT_EN
    n_frame = 4;
    exp_ovf = 1'b1;
`else
    n_frame = 6;
    exp_ovf = 1'b0;
`endif
    rxq.delete();
    n_acc = 0;
    fork
      send_entries(6, 1'b0);
      wait_frame("limit");
    join
    repeat (3) @(posedge clk);
    #1;
    build_exp(n_frame, 1'b0);
    compare_frame("limit");
    check_eq("limit accepted", 32'(n_acc), 32'd6);
    check_eq("limit overflow", 32'(dump_overflow), 32'(exp_ovf));
    check_eq("limit busy after", 32'(busy), 32'h0);

    // Reset while header byte 20 is presented, then a clean empty frame.
    rxq.delete();
    pulse_empty();
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (rxq.size() == 20) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check_eq("rst mid reached b20", 32'(done), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst mid tdata", 32'(tx_tdata), 32'h0);
    check_eq("rst mid tvalid", 32'(tx_tvalid), 32'h0);
    check_eq("rst mid tlast", 32'(tx_tlast), 32'h0);
    check_eq("rst mid busy", 32'(busy), 32'h0);
    check_eq("rst mid entry_tready", 32'(entry_tready), 32'h0);
    check_eq("rst mid overflow", 32'(dump_overflow), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sz = rxq.size();
    any_last = 1'b0;
    foreach (rxq[i]) if (rxq[i][8]) any_last = 1'b1;
    check_eq("rst mid partial len", 32'(sz), 32'd20);
    check_eq("rst mid no tlast", 32'(any_last), 32'h0);
    @(posedge clk);
    #1;
    rxq.delete();
    pulse_empty();
    wait_frame("post rst");
    repeat (3) @(posedge clk);
    #1;
    build_exp(0, 1'b1);
    compare_frame("post rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
